// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags/handshake in, strobes and status out.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero_flag;
  logic                mem_ack;
  logic                run;
  logic                ir_load;
  logic                pc_enable;
  logic                pc_load;
  logic                imm;
  logic                acc_load;
  logic                rf_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_req;
  logic                mem_we;
  logic                halted;
  logic                fault;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, zero_flag, mem_ack, run,
    output ir_load, pc_enable, pc_load, imm, acc_load, rf_write, alu_op,
           mem_req, mem_we, halted, fault, instr_count
  );

  modport slave (
    output opcode, zero_flag, mem_ack, run,
    input  ir_load, pc_enable, pc_load, imm, acc_load, rf_write, alu_op,
           mem_req, mem_we, halted, fault, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/HALT controller for the accumulator datapath.
// Define CTRL_MEM_TIMEOUT_EN to fault and halt after MEM_TIMEOUT unacknowledged MEM cycles.
module multicycle_ctrl #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(5);

  if (OPCODE_W < 4) begin : g_bad_opcode_w
    $error("OPCODE_W must be >= 4");
  end
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be >= 1");
  end

  state_t              r_state, w_next;
  logic                r_fault;
  logic [CNT_W-1:0]    r_count;
  logic [3:0]          w_op;
  logic                w_wide, w_illegal, w_timeout;
  logic                w_set_fault, w_clr_fault;
  logic                w_ir_load, w_pc_enable, w_pc_load, w_imm, w_acc_load, w_rf_write;
  logic                w_mem_req, w_mem_we, w_halted;
  logic [ALU_OP_W-1:0] w_alu_op;

  assign w_op      = bus.opcode[3:0];
  assign w_wide    = (bus.opcode >> 4) != '0;
  assign w_illegal = w_wide || (w_op >= 4'hA && w_op <= 4'hD);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait_cnt;

  // Counter holds the number of unacknowledged MEM cycles already seen.
  assign w_timeout = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || r_state != S_MEM) r_wait_cnt <= '0;
    else if (!bus.mem_ack)         r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_fault)      r_fault <= 1'b1;
      else if (w_clr_fault) r_fault <= 1'b0;
      if (w_pc_enable || w_pc_load) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_set_fault = 1'b0;
    w_clr_fault = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_enable = 1'b0;
    w_pc_load   = 1'b0;
    w_imm       = 1'b0;
    w_acc_load  = 1'b0;
    w_rf_write  = 1'b0;
    w_alu_op    = '0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_load = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_set_fault = 1'b1;
          w_next      = S_HALT;
        end else if (w_op == 4'hF)                 w_next = S_HALT;
        else if (w_op == 4'h6 || w_op == 4'h7)     w_next = S_MEM;
        else                                       w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (!w_wide) begin
          case (w_op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5: begin
              w_alu_op    = (w_op == 4'h5) ? ALU_XOR : ALU_OP_W'(w_op[1:0]);
              w_acc_load  = 1'b1;
              w_pc_enable = 1'b1;
            end
            4'h4: begin
              w_alu_op    = ALU_PASS_B;
              w_imm       = 1'b1;
              w_rf_write  = 1'b1;
              w_acc_load  = 1'b1;
              w_pc_enable = 1'b1;
            end
            4'hE: w_pc_enable = 1'b1;
            4'h8: w_pc_load   = 1'b1;
            4'h9: begin
              w_pc_load   = bus.zero_flag;
              w_pc_enable = !bus.zero_flag;
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_op == 4'h7);
        // An ack arriving in the timeout cycle still completes the access.
        if (bus.mem_ack) begin
          w_pc_enable = 1'b1;
          if (w_op == 4'h6) begin
            w_acc_load = 1'b1;
            w_alu_op   = ALU_PASS_B;
          end
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_set_fault = 1'b1;
          w_next      = S_HALT;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (bus.run) begin
          w_pc_enable = 1'b1;
          w_clr_fault = 1'b1;
          w_next      = S_FETCH;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.ir_load     = w_ir_load;
  assign bus.pc_enable   = w_pc_enable;
  assign bus.pc_load     = w_pc_load;
  assign bus.imm         = w_imm;
  assign bus.acc_load    = w_acc_load;
  assign bus.rf_write    = w_rf_write;
  assign bus.alu_op      = w_alu_op;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.halted      = w_halted;
  assign bus.fault       = r_fault;
  assign bus.instr_count = r_count;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model predicts the per-cycle
// strobe trace and the retired count (narrow CNT_W so wrap-around is exercised).
module tb_multicycle_ctrl;
  localparam int OW = 4, AW = 3, CW = 4, MT = 4;
  typedef logic [12:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPCODE_W(OW), .ALU_OP_W(AW), .CNT_W(CW)) bus();
  multicycle_ctrl #(.OPCODE_W(OW), .ALU_OP_W(AW), .CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int   checks = 0, failures = 0;
  int   mcount = 0;
  bit   mfault = 1'b0;
  vec_t exp_q[$], obs_q[$];

  // Trace vector: {ir,pe,pl,imm,acc,rf,mreq,mwe,halted,fault,alu_op}
  function automatic vec_t sv(bit ir, bit pe, bit pl, bit im, bit al, bit rw,
                              bit mr, bit mw, bit h, bit f, int alu);
    return {ir, pe, pl, im, al, rw, mr, mw, h, f, 3'(alu)};
  endfunction

  function automatic vec_t obs();
    return {bus.ir_load, bus.pc_enable, bus.pc_load, bus.imm, bus.acc_load, bus.rf_write,
            bus.mem_req, bus.mem_we, bus.halted, bus.fault, bus.alu_op};
  endfunction

  function automatic void retire();
    mcount = (mcount + 1) % (1 << CW);
  endfunction

  function automatic void halt_trace(int r);
    for (int k = 0; k < r; k++) exp_q.push_back(sv(0,0,0,0,0,0,0,0,1,mfault,0));
    exp_q.push_back(sv(0,1,0,0,0,0,0,0,1,mfault,0));
    retire();
    mfault = 1'b0;
  endfunction

  // d = MEM cycles before ack (-1: never acked), r = HALT cycles before run.
  function automatic void build_trace(int op, bit zf, int d, int r);
    int alu_of[6] = '{0, 1, 2, 3, 0, 4};
    exp_q.delete();
    exp_q.push_back(sv(1,0,0,0,0,0,0,0,0,mfault,0));
    exp_q.push_back(sv(0,0,0,0,0,0,0,0,0,mfault,0));
    case (op)
      0, 1, 2, 3, 5: begin exp_q.push_back(sv(0,1,0,0,1,0,0,0,0,mfault,alu_of[op])); retire(); end
      4:  begin exp_q.push_back(sv(0,1,0,1,1,1,0,0,0,mfault,5)); retire(); end
      14: begin exp_q.push_back(sv(0,1,0,0,0,0,0,0,0,mfault,0)); retire(); end
      8:  begin exp_q.push_back(sv(0,0,1,0,0,0,0,0,0,mfault,0)); retire(); end
      9:  begin exp_q.push_back(sv(0,!zf,zf,0,0,0,0,0,0,mfault,0)); retire(); end
      6, 7: begin
        if (d >= 0) begin
          for (int k = 0; k < d; k++) exp_q.push_back(sv(0,0,0,0,0,0,1,op==7,0,mfault,0));
          exp_q.push_back(sv(0,1,0,0,op==6,0,1,op==7,0,mfault,(op==6) ? 5 : 0));
          retire();
        end else begin
          for (int k = 0; k < MT; k++) exp_q.push_back(sv(0,0,0,0,0,0,1,op==7,0,mfault,0));
          mfault = 1'b1;
          halt_trace(r);
        end
      end
      15: halt_trace(r);
      default: begin mfault = 1'b1; halt_trace(r); end
    endcase
  endfunction

  // Starts and ends 1 time unit after a rising edge with the DUT in FETCH.
  task automatic do_instr(int op, bit zf, int d, int r);
    bit is_mem  = (op == 6 || op == 7);
    bit halting = (op == 15) || (op >= 10 && op <= 13) || (is_mem && d < 0);
    int run_at  = (is_mem && d < 0) ? 2 + MT : 2;
    build_trace(op, zf, d, r);
    obs_q.delete();
    bus.opcode = OW'(op);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.zero_flag = (i == 2) ? zf : 1'($urandom);
      bus.mem_ack   = !is_mem ? 1'($urandom) : (i < 2) ? 1'($urandom) : (i - 2 == d);
      bus.run       = !halting ? 1'($urandom) : (i < run_at) ? 1'b1 : (i == run_at + r);
      @(negedge clk);
      obs_q.push_back(obs());
      @(posedge clk); #1;
    end
    bus.run = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.opcode = '0; bus.zero_flag = 1'b1; bus.mem_ack = 1'b1; bus.run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== sv(1,0,0,0,0,0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", obs(), sv(1,0,0,0,0,0,0,0,0,0,0));
    end
    checks++;
    if (bus.instr_count !== '0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.run = 1'b0; bus.mem_ack = 1'b0;
    mcount = 0; mfault = 1'b0;
  endtask

  task automatic test_alu();
    int ops[8] = '{0, 1, 2, 3, 5, 4, 14, 8};
    for (int n = 0; n < 14; n++) begin
      int op = (n < 8) ? ops[n] : ops[$urandom_range(0, 7)];
      do_instr(op, 1'($urandom), 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL alu_trace op=%0h cyc=%0d got=%b exp=%b", op, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (bus.instr_count !== CW'(mcount)) begin
        failures++; $display("FAIL alu_count op=%0h got=%0d exp=%0d", op, bus.instr_count, mcount);
      end
    end
  endtask

  task automatic test_jz();
    for (int n = 0; n < 4; n++) begin
      bit zf = n[0] ^ 1'b1;
      do_instr(9, zf, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL jz_trace zf=%0b cyc=%0d got=%b exp=%b", zf, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (bus.instr_count !== CW'(mcount)) begin
        failures++; $display("FAIL jz_count got=%0d exp=%0d", bus.instr_count, mcount);
      end
    end
  endtask

  task automatic test_mem();
    int ops[4] = '{6, 7, 6, 7};
    int dly[4] = '{2, 0, 0, 4};
    for (int n = 0; n < 4; n++) begin
      do_instr(ops[n], 1'($urandom), dly[n], 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL mem_trace op=%0h cyc=%0d got=%b exp=%b", ops[n], i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (bus.instr_count !== CW'(mcount)) begin
        failures++; $display("FAIL mem_count got=%0d exp=%0d", bus.instr_count, mcount);
      end
    end
  endtask

  task automatic test_halt_illegal();
    int ops[4] = '{15, 11, 10, 13};
    int rs[4]  = '{10, 3, 0, 2};
    for (int n = 0; n < 4; n++) begin
      do_instr(ops[n], 1'($urandom), 0, rs[n]);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL halt_trace op=%0h cyc=%0d got=%b exp=%b", ops[n], i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({bus.instr_count, bus.fault, bus.ir_load} !== {CW'(mcount), mfault, 1'b1}) begin
        failures++; $display("FAIL halt_resume got=%0d/%0b/%0b exp=%0d/%0b/1",
                             bus.instr_count, bus.fault, bus.ir_load, mcount, mfault);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    bus.opcode = OW'(7); bus.mem_ack = 1'b0; bus.run = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we} !== 2'b11) begin
      failures++; $display("FAIL st_in_mem got=%b exp=11", {bus.mem_req, bus.mem_we});
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs(), bus.instr_count} !== {sv(1,0,0,0,0,0,0,0,0,0,0), CW'(0)}) begin
      failures++; $display("FAIL reset_mid_mem got=%b/%0d exp=%b/0", obs(), bus.instr_count,
                           sv(1,0,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mcount = 0; mfault = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      int op = $urandom_range(0, 15);
      do_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_trace op=%0h cyc=%0d got=%b exp=%b", op, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (bus.instr_count !== CW'(mcount)) begin
        failures++; $display("FAIL rand_count op=%0h got=%0d exp=%0d", op, bus.instr_count, mcount);
      end
    end
  endtask

`ifdef CTRL_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int ops[3] = '{6, 7, 6};
    for (int n = 0; n < 3; n++) begin
      do_instr(ops[n], 1'($urandom), (n == 2) ? MT - 1 : -1, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL timeout_trace op=%0h cyc=%0d got=%b exp=%b", ops[n], i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (bus.instr_count !== CW'(mcount)) begin
        failures++; $display("FAIL timeout_count got=%0d exp=%0d", bus.instr_count, mcount);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_jz();
    test_mem();
    test_halt_illegal();
    test_reset_mid_mem();
`ifdef CTRL_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
